// File: rtl/adder_pkg.sv
// rtl/adder_pkg.sv - shared FSM state type and index-width helper for the chunked adder
package adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    // Width of the chunk index counter; never narrower than one bit.
    function automatic int idx_width(input int num_chunks);
        return (num_chunks <= 1) ? 1 : $clog2(num_chunks);
    endfunction

endpackage

// File: rtl/adder_chunked_seq_if.sv
// rtl/adder_chunked_seq_if.sv - operand/result handshake bundle for the chunked adder
interface adder_chunked_seq_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/adder_chunk.sv
// rtl/adder_chunk.sv - combinational CHUNK-bit ripple adder built from full_adder cells
module adder_chunk #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout,
    output logic             msb_cin
);
    logic [CHUNK:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < CHUNK; i++) begin : g_fa
        full_adder u_fa (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (c[i]),
            .sum  (sum[i]),
            .cout (c[i+1])
        );
    end

    assign cout    = c[CHUNK];
    // Carry into the top bit of this chunk; used for signed overflow on the last chunk.
    assign msb_cin = c[CHUNK-1];
endmodule

// File: rtl/full_adder.sv
// rtl/full_adder.sv - single-bit full adder cell
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/adder_chunked_seq.sv
// rtl/adder_chunked_seq.sv - multi-cycle chunked adder; ADDER_SIGNED_OVF_EN enables signed overflow output
module adder_chunked_seq
    import adder_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    adder_chunked_seq_if.slave   bus
);
    localparam int CHUNK_SAFE = (CHUNK > 0) ? CHUNK : 1;
    localparam int NUM_CHUNKS = WIDTH / CHUNK_SAFE;
    localparam int IDX_W      = idx_width(NUM_CHUNKS);

    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_CALC = CALC;
    localparam logic [1:0] ST_DONE = DONE;

    if ((CHUNK == 0) || ((WIDTH % CHUNK_SAFE) != 0)) begin : g_bad_cfg
        $error("adder_chunked_seq: WIDTH must be a positive multiple of CHUNK");
    end

    logic [1:0]       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic             carry_q, carry_d, cout_q, cout_d;

    logic [CHUNK_SAFE-1:0] a_chunk, b_chunk, s_chunk;
    logic                  c_chunk, msb_cin;
    logic                  last_chunk;
    int                    base;

    // Select the operand slice addressed by the current chunk index.
    always_comb begin
        base       = int'(idx_q) * CHUNK_SAFE;
        a_chunk    = a_q[base +: CHUNK_SAFE];
        b_chunk    = b_q[base +: CHUNK_SAFE];
        last_chunk = (idx_q == IDX_W'(NUM_CHUNKS - 1));
    end

    adder_chunk #(.CHUNK(CHUNK_SAFE)) u_chunk (
        .a       (a_chunk),
        .b       (b_chunk),
        .cin     (carry_q),
        .sum     (s_chunk),
        .cout    (c_chunk),
        .msb_cin (msb_cin)
    );

`ifdef ADDER_SIGNED_OVF_EN
    logic ovf_q, ovf_d;
    // Signed overflow is the disagreement of the carries into and out of the MSB.
    always_comb begin
        ovf_d = ovf_q;
        if (state_q == ST_CALC && last_chunk) begin
            ovf_d = msb_cin ^ c_chunk;
        end
    end
    // Overflow flag register, cleared by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ovf_q <= 1'b0;
        else        ovf_q <= ovf_d;
    end
    assign bus.ovf = ovf_q;
`else
    logic unused_msb_cin;
    assign unused_msb_cin = msb_cin;
    assign bus.ovf        = 1'b0;
`endif

    // FSM next state: accept in IDLE, one chunk per cycle in CALC, hold in DONE.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    carry_d = bus.cin;
                    idx_d   = '0;
                    state_d = ST_CALC;
                end
            end
            ST_CALC: begin
                sum_d[base +: CHUNK_SAFE] = s_chunk;
                carry_d = c_chunk;
                if (last_chunk) begin
                    cout_d  = c_chunk;
                    idx_d   = '0;
                    state_d = ST_DONE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            ST_DONE: begin
                if (bus.out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, operand and result registers; reset discards any in-flight operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
        end
    end

    assign bus.in_ready  = (state_q == ST_IDLE);
    assign bus.out_valid = (state_q == ST_DONE);
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
endmodule

// File: tb/tb_adder_chunked_seq.sv
// tb/tb_adder_chunked_seq.sv - scoreboard bench for adder_chunked_seq (CHUNK=4 and CHUNK=16 instances)
module tb_adder_chunked_seq;
    localparam int W = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    adder_chunked_seq_if #(.WIDTH(W)) bus0 ();
    adder_chunked_seq_if #(.WIDTH(W)) bus1 ();

    adder_chunked_seq #(.WIDTH(W), .CHUNK(4))  dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
    adder_chunked_seq #(.WIDTH(W), .CHUNK(16)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
        exp_t         e;
        logic [W:0]   t;
        t      = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
        e.sum  = t[W-1:0];
        e.cout = t[W];
`ifdef ADDER_SIGNED_OVF_EN
        e.ovf  = (a[W-1] == b[W-1]) && (t[W-1] != a[W-1]);
`else
        e.ovf  = 1'b0;
`endif
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present operands on bus0 and return just after the accepting edge.
    task automatic send0(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
        int n;
        bus0.a        = a;
        bus0.b        = b;
        bus0.cin      = cin;
        bus0.in_valid = 1'b1;
        n = 0;
        while (!bus0.in_ready && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) chk("accept_timeout", 32'd1, 32'd0);
        tick();
        sb.push_back(model(a, b, cin));
        bus0.in_valid = 1'b0;
    endtask

    // Wait for a bus0 result, optionally check latency, stall for hold cycles, then consume it.
    task automatic recv0(input int lat, input int hold);
        int   n;
        exp_t e;
        n = 0;
        while (!bus0.out_valid && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) begin
            chk("result_timeout", 32'd1, 32'd0);
            return;
        end
        if (lat >= 0) chk("latency", n, lat);
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 32'd1, 32'd0);
            return;
        end
        e = sb.pop_front();
        for (int i = 0; i < hold; i++) begin
            chk("hold_sum", bus0.sum, e.sum);
            chk("hold_cout", bus0.cout, e.cout);
            chk("hold_in_ready", bus0.in_ready, 1'b0);
            tick();
        end
        chk("sum", bus0.sum, e.sum);
        chk("cout", bus0.cout, e.cout);
        chk("ovf", bus0.ovf, e.ovf);
        chk("out_valid", bus0.out_valid, 1'b1);
        bus0.out_ready = 1'b1;
        tick();
        bus0.out_ready = 1'b0;
        chk("out_valid_drop", bus0.out_valid, 1'b0);
        chk("in_ready_back", bus0.in_ready, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   n;
        exp_t e;
        bus0.in_valid = 1'b0; bus0.a = '0; bus0.b = '0; bus0.cin = 1'b0; bus0.out_ready = 1'b0;
        bus1.in_valid = 1'b0; bus1.a = '0; bus1.b = '0; bus1.cin = 1'b0; bus1.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();

        chk("rst_in_ready", bus0.in_ready, 1'b1);
        chk("rst_out_valid", bus0.out_valid, 1'b0);
        chk("rst_sum", bus0.sum, 16'h0000);
        chk("rst_cout", bus0.cout, 1'b0);
        chk("rst_ovf", bus0.ovf, 1'b0);

        // Full carry ripple across every chunk.
        send0(16'hFFFF, 16'h0001, 1'b0);
        recv0(4, 0);
        // Carry-in used, no carry out.
        send0(16'h1234, 16'h4321, 1'b1);
        recv0(4, 0);
        // Positive overflow into the sign bit.
        send0(16'h7FFF, 16'h0001, 1'b0);
        recv0(4, 0);

        // Backpressure: result held for 5 cycles in DONE.
        send0(16'h0F0F, 16'hF0F1, 1'b0);
        recv0(4, 5);

        // in_valid held with new operands during CALC must be ignored.
        send0(16'h1111, 16'h2222, 1'b0);
        bus0.a        = 16'hAAAA;
        bus0.b        = 16'h5555;
        bus0.cin      = 1'b1;
        bus0.in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("calc_in_ready", bus0.in_ready, 1'b0);
            tick();
        end
        recv0(-1, 0);
        tick();
        sb.push_back(model(16'hAAAA, 16'h5555, 1'b1));
        bus0.in_valid = 1'b0;
        recv0(4, 0);

        // Reset during the second CALC cycle discards the operation.
        send0(16'h8888, 16'h8888, 1'b0);
        tick();
        rst_n = 1'b0;
        #1;
        chk("midreset_out_valid", bus0.out_valid, 1'b0);
        chk("midreset_sum", bus0.sum, 16'h0000);
        void'(sb.pop_back());
        #2;
        rst_n = 1'b1;
        tick();
        chk("postreset_in_ready", bus0.in_ready, 1'b1);
        send0(16'h00FF, 16'h0001, 1'b0);
        recv0(4, 0);

        // Single-chunk instance: one-cycle latency.
        e = model(16'hABCD, 16'h1111, 1'b0);
        chk("c16_in_ready", bus1.in_ready, 1'b1);
        bus1.a        = 16'hABCD;
        bus1.b        = 16'h1111;
        bus1.cin      = 1'b0;
        bus1.in_valid = 1'b1;
        tick();
        bus1.in_valid = 1'b0;
        n = 0;
        while (!bus1.out_valid && n < 20) begin
            tick();
            n++;
        end
        chk("c16_latency", n, 1);
        chk("c16_sum", bus1.sum, e.sum);
        chk("c16_cout", bus1.cout, e.cout);
        bus1.out_ready = 1'b1;
        tick();
        bus1.out_ready = 1'b0;
        chk("c16_out_valid_drop", bus1.out_valid, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
